multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle main control unit for the MIPS-subset CPU. Sequences each instruction through

---
 rtl/ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_op_lut.sv | 43 ++++
 rtl/multicycle_ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode/funct values,
// ALU class codes, branch condition codes, datapath mux selects, the FSM
// state encoding and the decoded-instruction record produced by ctrl_op_lut.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BGEZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BNEZ  = 6'd6;
    localparam logic [5:0] OP_BGT   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FUNCT_JR = 6'd8;

    // ALU control classes
    localparam logic [2:0] ALU_OR    = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_ZERO  = 3'b110;

    // Branch conditions
    localparam logic [1:0] BR_EQ  = 2'd0;
    localparam logic [1:0] BR_GT  = 2'd1;
    localparam logic [1:0] BR_GEZ = 2'd2;
    localparam logic [1:0] BR_NE  = 2'd3;

    // PC source select
    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    // Register destination / write-back source selects
    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MDR  = 2'd1;
    localparam logic [1:0] WB_PC   = 2'd2;

    typedef enum logic [2:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_JR, CLS_IMM, CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_LOAD, CLS_STORE
    } instrClass_t;

    typedef struct packed {
        instrClass_t cls;
        logic [2:0]  aluOp;
        logic        aluSrc;
        logic [1:0]  branchType;
        logic        legal;
    } opInfo_t;

endpackage

// File: rtl/ctrl_op_lut.sv
// Combinational opcode decoder.
//   op    : instruction opcode IR[31:26]
//   funct : IR[5:0], only distinguishes jr within op 0
//   info  : instruction class, ALU class, ALU B-source, branch condition, legal flag
module ctrl_op_lut
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output opInfo_t    info
);

    always_comb begin
        info       = '0;
        info.cls   = CLS_RTYPE;
        info.legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                if (funct == FUNCT_JR) begin
                    info.cls = CLS_JR;
                end else begin
                    info.cls   = CLS_RTYPE;
                    info.aluOp = ALU_RTYPE;
                end
            end
            OP_ADDI: begin info.cls = CLS_IMM; info.aluOp = ALU_ADD; info.aluSrc = 1'b1; end
            OP_SLTI: begin info.cls = CLS_IMM; info.aluOp = ALU_SLT; info.aluSrc = 1'b1; end
            OP_ORI:  begin info.cls = CLS_IMM; info.aluOp = ALU_OR;  info.aluSrc = 1'b1; end
            OP_LUI:  begin info.cls = CLS_IMM; info.aluOp = ALU_LUI; info.aluSrc = 1'b1; end
            OP_BEQ:  begin info.cls = CLS_BRANCH; info.aluOp = ALU_SUB;  info.branchType = BR_EQ;  end
            OP_BNE:  begin info.cls = CLS_BRANCH; info.aluOp = ALU_SUB;  info.branchType = BR_NE;  end
            OP_BGT:  begin info.cls = CLS_BRANCH; info.aluOp = ALU_SUB;  info.branchType = BR_GT;  end
            OP_BNEZ: begin info.cls = CLS_BRANCH; info.aluOp = ALU_ZERO; info.branchType = BR_NE;  end
            OP_BGEZ: begin info.cls = CLS_BRANCH; info.aluOp = ALU_ZERO; info.branchType = BR_GEZ; end
            OP_J:    info.cls = CLS_JUMP;
            OP_JAL:  info.cls = CLS_JAL;
            OP_LW:   begin info.cls = CLS_LOAD;  info.aluOp = ALU_ADD; info.aluSrc = 1'b1; end
            OP_SW:   begin info.cls = CLS_STORE; info.aluOp = ALU_ADD; info.aluSrc = 1'b1; end
            default: info.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// datapath enables, handshakes with a variable-latency memory (with timeout
// and sticky bus-error halt) and counts retired instructions.
//   clk_i, rst_i (async active-low)
//   instr_op_i, funct_i          : IR fields, valid from DECODE onward
//   mem_ready_i / mem_req_o, mem_we_o : memory handshake
//   ir_write_o, pc_write_o, pc_src_o, branch_o, branch_type_o : IR/PC control
//   alu_op_o, alu_src_o, reg_dst_o, mem_to_reg_o, reg_write_o : datapath control
//   illegal_o (1-cycle pulse), bus_err_o (sticky), retired_cnt_o (wrapping)
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic [5:0]          funct_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic [1:0]          pc_src_o,
    output logic                branch_o,
    output logic [1:0]          branch_type_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                alu_src_o,
    output logic [1:0]          reg_dst_o,
    output logic [1:0]          mem_to_reg_o,
    output logic                reg_write_o,
    output logic                illegal_o,
    output logic                bus_err_o,
    output logic [CNT_W-1:0]    retired_cnt_o
);

    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t            state;
    logic [5:0]        opQ;
    logic [5:0]        functQ;
    logic [WAIT_W-1:0] waitCnt;
    logic [5:0]        lutOp;
    logic [5:0]        lutFunct;
    opInfo_t           info;

    // In DECODE the latched copy is not yet loaded, so legality is judged on the live IR.
    assign lutOp    = (state == ST_DECODE) ? instr_op_i : opQ;
    assign lutFunct = (state == ST_DECODE) ? funct_i    : functQ;

    ctrl_op_lut uOpLut (
        .op    (lutOp),
        .funct (lutFunct),
        .info  (info)
    );

    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_src_o      = PC_SEQ;
        branch_o      = 1'b0;
        branch_type_o = BR_EQ;
        alu_op_o      = '0;
        alu_src_o     = 1'b0;
        reg_dst_o     = RDST_RT;
        mem_to_reg_o  = WB_ALU;
        reg_write_o   = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req_o  = 1'b1;
                ir_write_o = mem_ready_i;
                pc_write_o = mem_ready_i;
            end
            ST_EXEC: begin
                alu_op_o  = ALU_OP_W'(info.aluOp);
                alu_src_o = info.aluSrc;
                case (info.cls)
                    CLS_JR: begin
                        pc_write_o = 1'b1;
                        pc_src_o   = PC_REG;
                    end
                    CLS_BRANCH: begin
                        branch_o      = 1'b1;
                        pc_src_o      = PC_BRANCH;
                        branch_type_o = info.branchType;
                    end
                    CLS_JUMP: begin
                        pc_write_o = 1'b1;
                        pc_src_o   = PC_JUMP;
                    end
                    CLS_JAL: begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = PC_JUMP;
                        reg_write_o  = 1'b1;
                        reg_dst_o    = RDST_RA;
                        mem_to_reg_o = WB_PC;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (info.cls == CLS_STORE);
            end
            ST_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = (info.cls == CLS_RTYPE) ? RDST_RD : RDST_RT;
                mem_to_reg_o = (info.cls == CLS_LOAD) ? WB_MDR : WB_ALU;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= ST_RST;
            opQ           <= '0;
            functQ        <= '0;
            waitCnt       <= '0;
            illegal_o     <= 1'b0;
            bus_err_o     <= 1'b0;
            retired_cnt_o <= '0;
        end else begin
            illegal_o <= 1'b0;
            case (state)
                ST_RST:   state <= ST_FETCH;
                ST_FETCH: if (mem_ready_i) state <= ST_DECODE;
                ST_DECODE: begin
                    opQ    <= instr_op_i;
                    functQ <= funct_i;
                    if (info.legal) begin
                        state <= ST_EXEC;
                    end else begin
                        illegal_o <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    case (info.cls)
                        CLS_RTYPE, CLS_IMM:  state <= ST_WB;
                        CLS_LOAD, CLS_STORE: state <= ST_MEM;
                        default: begin
                            retired_cnt_o <= retired_cnt_o + 1'b1;
                            state         <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        if (info.cls == CLS_STORE) begin
                            retired_cnt_o <= retired_cnt_o + 1'b1;
                            state         <= ST_FETCH;
                        end else begin
                            state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    retired_cnt_o <= retired_cnt_o + 1'b1;
                    state         <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase

            // Placed after the case so a timeout overrides the "stay" of FETCH/MEM.
            if (state == ST_FETCH || state == ST_MEM) begin
                if (mem_ready_i) begin
                    waitCnt <= '0;
                end else if (WAIT_MAX > 0) begin
                    if (waitCnt == WAIT_W'(WAIT_MAX - 1)) begin
                        bus_err_o <= 1'b1;
                        state     <= ST_HALT;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rstN;
    logic [5:0] op;
    logic [5:0] funct;
    logic       ready;

    logic       memReq, memWe, irWrite, pcWrite, branch, aluSrc, regWrite, illegal, busErr;
    logic [1:0] pcSrc, branchType, regDst, memToReg;
    logic [2:0] aluOp;
    logic [3:0] retired;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       irW;
        logic       pcW;
        logic [1:0] pcSrc;
        logic       br;
        logic [1:0] bt;
        logic [2:0] alu;
        logic       aSrc;
        logic [1:0] rDst;
        logic [1:0] m2r;
        logic       rW;
        logic       ill;
        logic       berr;
    } ctl_t;

    ctl_t ctl;
    assign ctl = {memReq, memWe, irWrite, pcWrite, pcSrc, branch, branchType, aluOp,
                  aluSrc, regDst, memToReg, regWrite, illegal, busErr};

    int nCompared   = 0;
    int nMismatched = 0;
    int expCnt      = 0;

    localparam logic [5:0] BR_OPS [5] = '{6'd4, 6'd5, 6'd7, 6'd6, 6'd1};
    localparam logic [2:0] BR_ALU [5] = '{3'b001, 3'b001, 3'b001, 3'b110, 3'b110};
    localparam logic [1:0] BR_BT  [5] = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [5:0] IM_OPS [4] = '{6'd8, 6'd10, 6'd13, 6'd15};
    localparam logic [2:0] IM_ALU [4] = '{3'b100, 3'b101, 3'b000, 3'b011};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .ALU_OP_W (3),
        .WAIT_MAX (4),
        .CNT_W    (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rstN),
        .instr_op_i    (op),
        .funct_i       (funct),
        .mem_ready_i   (ready),
        .mem_req_o     (memReq),
        .mem_we_o      (memWe),
        .ir_write_o    (irWrite),
        .pc_write_o    (pcWrite),
        .pc_src_o      (pcSrc),
        .branch_o      (branch),
        .branch_type_o (branchType),
        .alu_op_o      (aluOp),
        .alu_src_o     (aluSrc),
        .reg_dst_o     (regDst),
        .mem_to_reg_o  (memToReg),
        .reg_write_o   (regWrite),
        .illegal_o     (illegal),
        .bus_err_o     (busErr),
        .retired_cnt_o (retired)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkCtl(input string tag, input ctl_t e);
        checkEq(tag, 32'(ctl), 32'(e));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Starts in a FETCH cycle; returns in the cycle after DECODE.
    task automatic doFetch(input logic [5:0] o, input logic [5:0] f, input string tag,
                           input logic expIll);
        ctl_t e;
        op    = o;
        funct = f;
        ready = 1'b1;
        #1;
        e     = '0;
        e.req = 1'b1;
        e.irW = 1'b1;
        e.pcW = 1'b1;
        e.ill = expIll;
        checkCtl({tag, "_fetch"}, e);
        nextCycle();
        #1;
        checkCtl({tag, "_decode"}, '0);
        nextCycle();
    endtask

    task automatic retireCheck(input string tag);
        nextCycle();
        expCnt = (expCnt + 1) % 16;
        checkEq({tag, "_cnt"}, 32'(retired), 32'(expCnt));
    endtask

    initial begin
        ctl_t e;
        rstN  = 1'b0;
        ready = 1'b0;
        op    = '0;
        funct = '0;
        #3;
        checkCtl("reset_ctl", '0);
        checkEq("reset_cnt", 32'(retired), 32'd0);
        @(posedge clk);
        #2;
        rstN = 1'b1;
        #1;
        checkCtl("rst_state", '0);
        nextCycle();

        // add: FETCH, DECODE, EXEC, WB
        doFetch(6'd0, 6'h20, "add", 1'b0);
        e = '0; e.alu = 3'b010;
        #1; checkCtl("add_exec", e);
        nextCycle();
        e = '0; e.rW = 1'b1; e.rDst = 2'd1;
        #1; checkCtl("add_wb", e);
        checkEq("add_cnt_wb", 32'(retired), 32'd0);
        retireCheck("add");

        // lw with 3 wait cycles in MEM
        doFetch(6'd35, 6'd0, "lw", 1'b0);
        e = '0; e.alu = 3'b100; e.aSrc = 1'b1;
        #1; checkCtl("lw_exec", e);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            ready = (i == 3);
            e = '0; e.req = 1'b1;
            #1; checkCtl("lw_mem", e);
        end
        nextCycle();
        e = '0; e.rW = 1'b1; e.m2r = 2'd1;
        #1; checkCtl("lw_wb", e);
        retireCheck("lw");

        // jal
        doFetch(6'd3, 6'd0, "jal", 1'b0);
        e = '0; e.pcW = 1'b1; e.pcSrc = 2'd2; e.rW = 1'b1; e.rDst = 2'd2; e.m2r = 2'd2;
        #1; checkCtl("jal_exec", e);
        retireCheck("jal");

        // illegal op 63: pulse seen in the following FETCH, no retire
        doFetch(6'd63, 6'd0, "ill", 1'b0);
        checkEq("ill_cnt", 32'(retired), 32'(expCnt));

        // sw, zero-wait (its FETCH carries the illegal pulse)
        doFetch(6'd43, 6'd0, "sw", 1'b1);
        e = '0; e.alu = 3'b100; e.aSrc = 1'b1;
        #1; checkCtl("sw_exec", e);
        nextCycle();
        e = '0; e.req = 1'b1; e.we = 1'b1;
        #1; checkCtl("sw_mem", e);
        retireCheck("sw");

        // jr
        doFetch(6'd0, 6'd8, "jr", 1'b0);
        e = '0; e.pcW = 1'b1; e.pcSrc = 2'd3;
        #1; checkCtl("jr_exec", e);
        retireCheck("jr");

        for (int i = 0; i < 4; i++) begin
            doFetch(IM_OPS[i], 6'd0, "imm", 1'b0);
            e = '0; e.alu = IM_ALU[i]; e.aSrc = 1'b1;
            #1; checkCtl("imm_exec", e);
            nextCycle();
            e = '0; e.rW = 1'b1;
            #1; checkCtl("imm_wb", e);
            retireCheck("imm");
        end

        for (int i = 0; i < 5; i++) begin
            doFetch(BR_OPS[i], 6'd0, "br", 1'b0);
            e = '0; e.br = 1'b1; e.pcSrc = 2'd1; e.bt = BR_BT[i]; e.alu = BR_ALU[i];
            #1; checkCtl("br_exec", e);
            retireCheck("br");
        end

        doFetch(6'd2, 6'd0, "j", 1'b0);
        e = '0; e.pcW = 1'b1; e.pcSrc = 2'd2;
        #1; checkCtl("j_exec", e);
        retireCheck("j");

        // reset during MEM of sw aborts without retiring
        doFetch(6'd43, 6'd0, "swrst", 1'b0);
        nextCycle();
        ready = 1'b0;
        e = '0; e.req = 1'b1; e.we = 1'b1;
        #1; checkCtl("swrst_mem", e);
        rstN = 1'b0;
        #1;
        checkCtl("swrst_ctl", '0);
        checkEq("swrst_cnt", 32'(retired), 32'd0);
        expCnt = 0;
        nextCycle();
        rstN = 1'b1;
        #1; checkCtl("swrst_rst_state", '0);
        nextCycle();

        // 16 branches wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) begin
            doFetch(6'd4, 6'd0, "wrap", 1'b0);
            retireCheck("wrap");
        end

        // timeout: ready held low in FETCH
        for (int i = 0; i < 4; i++) begin
            ready = 1'b0;
            e = '0; e.req = 1'b1;
            #1; checkCtl("to_wait", e);
            nextCycle();
        end
        for (int i = 0; i < 20; i++) begin
            ready = 1'(i % 2);
            e = '0; e.berr = 1'b1;
            #1; checkCtl("to_halt", e);
            nextCycle();
        end
        rstN = 1'b0;
        #1; checkCtl("to_reset", '0);
        nextCycle();
        rstN = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
